// File: rtl/min_os_pkg.sv
// MinOS link definitions shared by the TX and RX halves of the UART link.
// Holds the frame byte constants, the frame FSM state encoding and small
// helpers for the TYPE/LEN bytes and the 8-bit wrapping checksum.
package min_os_pkg;

   localparam logic [7:0] MINOS_SYNC         = 8'hA5;
   localparam logic [7:0] MINOS_TYPE_LEDS    = 8'h01;
   localparam logic [7:0] MINOS_TYPE_DISPLAY = 8'h02;
   localparam logic [7:0] MINOS_LEN_LEDS     = 8'h01;
   localparam logic [7:0] MINOS_LEN_DISPLAY  = 8'h40;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SYNC    = 3'd1,
      ST_TYPE    = 3'd2,
      ST_LEN     = 3'd3,
      ST_PAYLOAD = 3'd4,
      ST_CSUM    = 3'd5
   } minos_state_e;

   function automatic logic [7:0] minos_type(input logic is_disp);
      return is_disp ? MINOS_TYPE_DISPLAY : MINOS_TYPE_LEDS;
   endfunction

   function automatic logic [7:0] minos_len(input logic is_disp);
      return is_disp ? MINOS_LEN_DISPLAY : MINOS_LEN_LEDS;
   endfunction

   // Checksum is a plain modulo-256 sum of TYPE, LEN and payload.
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit 0, data LSB first, stop bit 1, each bit
// CLKS_PER_BIT cycles. A new byte may be started in the final cycle of the
// previous stop bit, so consecutive bytes leave no idle gap on the line.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   data       : byte to send, captured when start is accepted
//   start      : load data (accepted while idle or in the last stop-bit cycle)
//   tx         : registered serial output, idle high
//   done       : high during the last cycle of the stop bit
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       start,
   output logic       tx,
   output logic       done
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   logic          active_r;
   logic [3:0]    bit_r;
   logic [CW-1:0] cnt_r;
   logic [7:0]    shift_r;
   logic          tx_r;
   logic          last_s;

   assign last_s = active_r && (bit_r == 4'd9) && (cnt_r == CNT_LAST);
   assign done   = last_s;
   assign tx     = tx_r;

   // Bit timing and shifting; bit_r 0 = start, 1..8 = data, 9 = stop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_r <= 1'b0;
         bit_r    <= 4'd0;
         cnt_r    <= '0;
         shift_r  <= 8'h00;
         tx_r     <= 1'b1;
      end else if (start && (!active_r || last_s)) begin
         active_r <= 1'b1;
         bit_r    <= 4'd0;
         cnt_r    <= '0;
         shift_r  <= data;
         tx_r     <= 1'b0;
      end else if (active_r) begin
         if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            if (bit_r == 4'd9) begin
               active_r <= 1'b0;
               tx_r     <= 1'b1;
            end else begin
               bit_r <= bit_r + 4'd1;
               if (bit_r == 4'd8) begin
                  tx_r <= 1'b1;
               end else begin
                  tx_r    <= shift_r[0];
                  shift_r <= {1'b0, shift_r[7:1]};
               end
            end
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end else begin
         tx_r <= 1'b1;
      end
   end

endmodule

// File: rtl/min_os_frame_tx.sv
// MinOS link transmitter: on each refresh sends an LED frame then a DISPLAY
// frame (SYNC | TYPE | LEN | payload | CSUM) over 8N1 UART.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   leds       : LED byte, snapshotted at refresh start
//   display    : 64-byte display, byte k = display[8k+7:8k], snapshotted at refresh start
//   send_now   : one-cycle request for an immediate refresh
//   TX         : UART serial output, idle high
//   busy       : high from refresh start until the DISPLAY frame's last stop bit ends
//   frame_done : one-cycle pulse after each frame's checksum stop bit
module min_os_frame_tx
   import min_os_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 868,
   parameter int REFRESH_CYCLES = 3_333_333
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic [7:0]   leds,
   input  logic [511:0] display,
   input  logic         send_now,
   output logic         TX,
   output logic         busy,
   output logic         frame_done
);

   localparam int RW = $clog2(REFRESH_CYCLES);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

   minos_state_e state_r, state_nx_s;
   logic [5:0]   idx_r, idx_nx_s;
   logic         disp_r, disp_nx_s;
   logic [RW-1:0] ref_cnt_r;
   logic         pend_r;
   logic         busy_r;
   logic         fd_r;
   logic [7:0]   csum_r;
   logic [7:0]   leds_sh_r;
   logic [511:0] disp_sh_r;
   logic         trig_s;
   logic         launch_s;
   logic         start_s;
   logic         done_s;
   logic [7:0]   byte_s;

   assign trig_s     = send_now | (ref_cnt_r == REF_LAST);
   assign busy       = busy_r;
   assign frame_done = fd_r;

   // Free-running refresh timer, wraps every REFRESH_CYCLES cycles.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ref_cnt_r <= '0;
      end else if (ref_cnt_r == REF_LAST) begin
         ref_cnt_r <= '0;
      end else begin
         ref_cnt_r <= ref_cnt_r + RW'(1);
      end
   end

   // Frame FSM next state; the serialiser is always fed the byte of the state being entered.
   always_comb begin
      state_nx_s = state_r;
      idx_nx_s   = idx_r;
      disp_nx_s  = disp_r;
      launch_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (trig_s || pend_r) begin
               state_nx_s = ST_SYNC;
               disp_nx_s  = 1'b0;
               launch_s   = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SYNC: begin
            if (done_s) state_nx_s = ST_TYPE;
            else        state_nx_s = ST_SYNC;
         end
         ST_TYPE: begin
            if (done_s) state_nx_s = ST_LEN;
            else        state_nx_s = ST_TYPE;
         end
         ST_LEN: begin
            if (done_s) begin
               state_nx_s = ST_PAYLOAD;
               idx_nx_s   = 6'd0;
            end else begin
               state_nx_s = ST_LEN;
            end
         end
         ST_PAYLOAD: begin
            if (done_s) begin
               if ({2'b00, idx_r} == (minos_len(disp_r) - 8'd1)) begin
                  state_nx_s = ST_CSUM;
               end else begin
                  idx_nx_s = idx_r + 6'd1;
               end
            end else begin
               state_nx_s = ST_PAYLOAD;
            end
         end
         ST_CSUM: begin
            if (done_s) begin
               if (disp_r) begin
                  state_nx_s = ST_IDLE;
               end else begin
                  state_nx_s = ST_SYNC;
                  disp_nx_s  = 1'b1;
               end
            end else begin
               state_nx_s = ST_CSUM;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Byte mux and serialiser start for the state being entered.
   always_comb begin
      start_s = launch_s || (done_s && (state_nx_s != ST_IDLE));
      case (state_nx_s)
         ST_SYNC:    byte_s = MINOS_SYNC;
         ST_TYPE:    byte_s = minos_type(disp_nx_s);
         ST_LEN:     byte_s = minos_len(disp_nx_s);
         ST_PAYLOAD: byte_s = disp_nx_s ? disp_sh_r[{idx_nx_s, 3'b000} +: 8] : leds_sh_r;
         ST_CSUM:    byte_s = csum_r;
         default:    byte_s = 8'h00;
      endcase
   end

   // FSM, pending flag, snapshots, checksum and status outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r   <= ST_IDLE;
         idx_r     <= 6'd0;
         disp_r    <= 1'b0;
         pend_r    <= 1'b0;
         busy_r    <= 1'b0;
         fd_r      <= 1'b0;
         csum_r    <= 8'h00;
         leds_sh_r <= 8'h00;
         disp_sh_r <= '0;
      end else begin
         state_r <= state_nx_s;
         idx_r   <= idx_nx_s;
         disp_r  <= disp_nx_s;
         busy_r  <= (state_nx_s != ST_IDLE);
         fd_r    <= done_s && (state_r == ST_CSUM);
         // A trigger arriving while busy is remembered once; extra triggers merge.
         if (launch_s) begin
            pend_r <= 1'b0;
         end else if (trig_s && (state_r != ST_IDLE)) begin
            pend_r <= 1'b1;
         end else begin
            pend_r <= pend_r;
         end
         if (launch_s) begin
            leds_sh_r <= leds;
            disp_sh_r <= display;
         end else begin
            leds_sh_r <= leds_sh_r;
            disp_sh_r <= disp_sh_r;
         end
         if (start_s && (state_nx_s == ST_TYPE)) begin
            csum_r <= byte_s;
         end else if (start_s && ((state_nx_s == ST_LEN) || (state_nx_s == ST_PAYLOAD))) begin
            csum_r <= csum_add(csum_r, byte_s);
         end else begin
            csum_r <= csum_r;
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk   (CLK),
      .rst_n (RST_N),
      .data  (byte_s),
      .start (start_s),
      .tx    (TX),
      .done  (done_s)
   );

endmodule

// File: tb/tb_min_os_frame_tx.sv
// Self-checking bench for min_os_frame_tx: an independent cycle model of the
// refresh scheduling pushes expected frame bytes to a queue at each refresh
// start; a UART monitor decodes TX and compares bytes as they arrive.
module tb_min_os_frame_tx;
   import min_os_pkg::*;

   localparam int CPB     = 4;
   localparam int RC      = 2000;
   localparam int REF_LEN = 73 * 10 * CPB;

   logic         CLK;
   logic         RST_N;
   logic [7:0]   leds;
   logic [511:0] display;
   logic         send_now;
   logic         TX;
   logic         busy;
   logic         frame_done;

   int n_checks = 0;
   int n_fails  = 0;

   // model state
   int   m_cnt = 0;
   int   m_left = 0;
   int   m_starts = 0;
   logic m_pend = 1'b0;
   logic m_busy = 1'b0;
   logic m_fd = 1'b0;
   logic m_trig;
   logic [7:0] exp_q[$];

   // monitor state
   logic       mon_on = 1'b0;
   int         mon_off = 0;
   logic [7:0] mon_byte;
   logic [7:0] mon_exp;
   int         rx_cnt = 0;
   int         rx_mark;
   int         bi;
   int         w;

   min_os_frame_tx #(
      .CLKS_PER_BIT   (CPB),
      .REFRESH_CYCLES (RC)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .leds       (leds),
      .display    (display),
      .send_now   (send_now),
      .TX         (TX),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_refresh(input logic [7:0] l, input logic [511:0] d);
      logic [7:0] cs;
      logic [7:0] b;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h01);
      exp_q.push_back(l);
      cs = 8'h02 + l;
      exp_q.push_back(cs);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h40);
      cs = 8'h42;
      for (int k = 0; k < 64; k++) begin
         b = d[8*k +: 8];
         exp_q.push_back(b);
         cs = cs + b;
      end
      exp_q.push_back(cs);
   endtask

   // Reference model of refresh scheduling.
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_cnt  = 0;
         m_pend = 1'b0;
         m_busy = 1'b0;
         m_left = 0;
         m_fd   = 1'b0;
         exp_q.delete();
      end else begin
         m_trig = send_now || (m_cnt == RC - 1);
         m_fd   = 1'b0;
         if (!m_busy) begin
            if (m_trig || m_pend) begin
               m_pend = 1'b0;
               m_busy = 1'b1;
               m_left = REF_LEN;
               push_refresh(leds, display);
               m_starts++;
            end
         end else begin
            if (m_trig) m_pend = 1'b1;
            m_left--;
            if (m_left == REF_LEN - 5 * 10 * CPB) m_fd = 1'b1;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_fd   = 1'b1;
            end
         end
         m_cnt = (m_cnt == RC - 1) ? 0 : m_cnt + 1;
      end
   end

   // Per-cycle status checks against the model.
   always @(negedge CLK) begin
      if (RST_N) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("frame_done", 32'(frame_done), 32'(m_fd));
         if (!m_busy) chk("tx_idle", 32'(TX), 32'd1);
      end
   end

   // UART monitor: samples mid-bit, compares each decoded byte with the queue head.
   always @(negedge CLK) begin
      if (!RST_N) begin
         mon_on  = 1'b0;
         mon_off = 0;
      end else if (!mon_on) begin
         if (TX == 1'b0) begin
            mon_on  = 1'b1;
            mon_off = 0;
         end
      end else begin
         mon_off++;
         if ((mon_off % 4 == 2) && (mon_off >= 6) && (mon_off <= 34)) begin
            bi = (mon_off - 6) / 4;
            mon_byte[bi[2:0]] = TX;
         end
         if (mon_off == 38) begin
            chk("stop_bit", 32'(TX), 32'd1);
            chk("rx_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               mon_exp = exp_q.pop_front();
               chk($sformatf("rx_byte%0d", rx_cnt), 32'(mon_byte), 32'(mon_exp));
            end
            rx_cnt++;
         end
         if (mon_off == 39) mon_on = 1'b0;
      end
   end

   task automatic wait_starts(input int n);
      for (int i = 0; i < 8000 && m_starts < n; i++) @(negedge CLK);
   endtask

   task automatic pulse_send;
      send_now = 1'b1;
      @(negedge CLK);
      send_now = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N    = 1'b0;
      send_now = 1'b0;
      leds     = 8'h00;
      display  = '0;
      @(negedge CLK);
      chk("rst_tx", 32'(TX), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (100) @(negedge CLK);
      chk("idle100_tx", 32'(TX), 32'd1);
      chk("idle100_busy", 32'(busy), 32'd0);

      // Refresh A carries 5A; timer trigger during A queues refresh B.
      leds = 8'h5A;
      pulse_send();
      repeat (1000) @(negedge CLK);
      leds = 8'hC3;
      wait_starts(2);
      repeat (10) @(negedge CLK);
      leds    = 8'h00;
      display = '0;
      display[7:0] = 8'hFF;

      // Refresh C carries display byte0 FF; several send_now pulses while busy merge.
      wait_starts(3);
      repeat (300) @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         pulse_send();
         repeat (50) @(negedge CLK);
      end

      // Reset in the middle of DISPLAY payload byte 10 of refresh D.
      wait_starts(4);
      repeat (5 * 40 + 13 * 40 + 20) @(posedge CLK);
      #2;
      chk("pre_reset_busy", 32'(busy), 32'd1);
      RST_N = 1'b0;
      #1;
      chk("reset_tx_now", 32'(TX), 32'd1);
      chk("reset_busy_now", 32'(busy), 32'd0);
      chk("reset_fd_now", 32'(frame_done), 32'd0);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      rx_mark = rx_cnt;
      repeat (5) @(negedge CLK);
      leds = 8'h96;
      for (int k = 0; k < 16; k++) display[32*k +: 32] = $urandom();
      pulse_send();

      for (int i = 0; i < 50 && TX !== 1'b0; i++) @(negedge CLK);
      w = 0;
      while (TX === 1'b0 && w < 50) begin
         w++;
         @(negedge CLK);
      end
      chk("start_bit_width", 32'(w), 32'd4);

      repeat (3000) @(negedge CLK);
      chk("pair_complete", 32'((rx_cnt - rx_mark) >= 73), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
